pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid_pkg.sv | 15 +
 rtl/pipe_stage_skid.sv | 119 +++++++++++
 tb/tb_pipe_stage_skid.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for pipe_* stages: state encoding and default widths.
package pipe_stage_skid_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CTRL_W_DEF = 3;
    localparam int unsigned DEST_W_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with one-entry skid buffer; in_ready is registered
// so there is no combinational path from out_ready back upstream.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DEST_W = DEST_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_rdata,
    output logic [DATA_W-1:0] o_alu,
    output logic [DEST_W-1:0] o_dest,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned PAY_W    = CTRL_W + 2 * DATA_W + DEST_W;
    localparam int unsigned CTRL_LSB = 2 * DATA_W + DEST_W;

    state_t             state_q, state_d;
    logic [PAY_W-1:0]   main_q, main_d;
    logic [PAY_W-1:0]   skid_q, skid_d;
    logic [PAY_W-1:0]   in_pay;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_xfer;
    logic               out_xfer;

    assign in_pay   = {in_ctrl, in_rdata, in_alu, in_dest};
    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    // Next state and storage; entering EMPTY zeroes the control flags so a
    // bubble never carries RegWrite/MemRead, while data fields keep their value.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = {{CTRL_W{1'b0}}, main_q[CTRL_LSB-1:0]};
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_ONE;
                        main_d  = in_pay;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_pay;
                    end else if (in_xfer) begin
                        state_d = ST_FULL;
                        skid_d  = in_pay;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                        main_d  = {{CTRL_W{1'b0}}, main_q[CTRL_LSB-1:0]};
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Saturating stall counter
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_q && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign stall_cnt = cnt_q;
    assign o_ctrl    = main_q[PAY_W-1:CTRL_LSB];
    assign o_rdata   = main_q[DEST_W+DATA_W +: DATA_W];
    assign o_alu     = main_q[DEST_W +: DATA_W];
    assign o_dest    = main_q[DEST_W-1:0];

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, reset/saturation sequences,
// and a random run against a queue-based reference model.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready;
    logic [2:0]  in_ctrl;
    logic [31:0] in_rdata, in_alu;
    logic [4:0]  in_dest;

    logic        in_ready, out_valid;
    logic [2:0]  o_ctrl;
    logic [31:0] o_rdata, o_alu;
    logic [4:0]  o_dest;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2;
    logic [2:0]  o_ctrl2;
    logic [31:0] o_rdata2, o_alu2;
    logic [4:0]  o_dest2;
    logic [3:0]  stall_cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_rdata(in_rdata), .in_alu(in_alu), .in_dest(in_dest),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .o_ctrl(o_ctrl), .o_rdata(o_rdata), .o_alu(o_alu), .o_dest(o_dest),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_ctrl(in_ctrl), .in_rdata(in_rdata), .in_alu(in_alu), .in_dest(in_dest),
        .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
        .o_ctrl(o_ctrl2), .o_rdata(o_rdata2), .o_alu(o_alu2), .o_dest(o_dest2),
        .stall_cnt(stall_cnt2)
    );

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] alu;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_alu;
        logic [15:0] e_st;
    } vec_t;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  dest;
    } pay_t;

    localparam logic [31:0] RD_XOR = 32'hA5A5_A5A5;

    vec_t vec [13];
    pay_t q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [2:0] c, input logic [31:0] a);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_ctrl   = c;
        in_alu    = a;
        in_rdata  = a ^ RD_XOR;
        in_dest   = a[4:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ea;
        logic [15:0] mcnt;
        logic        iv, ordy, fl, in_x, out_x;
        pay_t        p;

        //            iv    rdy   fl    alu           ov    ir    exp alu       stall
        vec[0]  = '{1'b1, 1'b1, 1'b0, 32'h11,       1'b1, 1'b1, 32'h11,       16'd0};
        vec[1]  = '{1'b1, 1'b1, 1'b0, 32'h22,       1'b1, 1'b1, 32'h22,       16'd0};
        vec[2]  = '{1'b1, 1'b1, 1'b0, 32'h33,       1'b1, 1'b1, 32'h33,       16'd0};
        vec[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h33,       16'd0};
        vec[4]  = '{1'b1, 1'b0, 1'b0, 32'hAA,       1'b1, 1'b1, 32'hAA,       16'd0};
        vec[5]  = '{1'b1, 1'b0, 1'b0, 32'hBB,       1'b1, 1'b0, 32'hAA,       16'd1};
        vec[6]  = '{1'b1, 1'b0, 1'b0, 32'hCC,       1'b1, 1'b0, 32'hAA,       16'd2};
        vec[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hBB,       16'd2};
        vec[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hBB,       16'd2};
        vec[9]  = '{1'b1, 1'b0, 1'b0, 32'hD1,       1'b1, 1'b1, 32'hD1,       16'd2};
        vec[10] = '{1'b1, 1'b0, 1'b0, 32'hD2,       1'b1, 1'b0, 32'hD1,       16'd3};
        vec[11] = '{1'b1, 1'b0, 1'b1, 32'hC3,       1'b0, 1'b1, 32'hD1,       16'd4};
        vec[12] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hD1,       16'd4};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        #12;
        chk("rst_ov",    64'(out_valid), 64'd0);
        chk("rst_ir",    64'(in_ready),  64'd0);
        chk("rst_ctrl",  64'(o_ctrl),    64'd0);
        chk("rst_alu",   64'(o_alu),     64'd0);
        chk("rst_rdata", 64'(o_rdata),   64'd0);
        chk("rst_dest",  64'(o_dest),    64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ir_after_rst", 64'(in_ready), 64'd1);

        for (int i = 0; i < 13; i++) begin
            drive(vec[i].iv, vec[i].ordy, vec[i].fl, 3'b101, vec[i].alu);
            tick();
            ea = vec[i].e_alu;
            chk($sformatf("v%0d_ov", i),    64'(out_valid), 64'(vec[i].e_ov));
            chk($sformatf("v%0d_ir", i),    64'(in_ready),  64'(vec[i].e_ir));
            chk($sformatf("v%0d_alu", i),   64'(o_alu),     64'(ea));
            chk($sformatf("v%0d_rdata", i), 64'(o_rdata),   64'(ea ^ RD_XOR));
            chk($sformatf("v%0d_dest", i),  64'(o_dest),    64'(ea[4:0]));
            chk($sformatf("v%0d_ctrl", i),  64'(o_ctrl),    vec[i].e_ov ? 64'd5 : 64'd0);
            chk($sformatf("v%0d_stall", i), 64'(stall_cnt), 64'(vec[i].e_st));
            chk($sformatf("v%0d_stall4", i), 64'(stall_cnt2), 64'(vec[i].e_st));
        end

        // Async reset pulse between edges while FULL
        drive(1'b1, 1'b0, 1'b0, 3'b011, 32'hE1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 3'b011, 32'hE2);
        tick();
        chk("full_ir", 64'(in_ready), 64'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ov",     64'(out_valid),  64'd0);
        chk("arst_ir",     64'(in_ready),   64'd0);
        chk("arst_ctrl",   64'(o_ctrl),     64'd0);
        chk("arst_alu",    64'(o_alu),      64'd0);
        chk("arst_rdata",  64'(o_rdata),    64'd0);
        chk("arst_dest",   64'(o_dest),     64'd0);
        chk("arst_stall",  64'(stall_cnt),  64'd0);
        chk("arst_stall4", 64'(stall_cnt2), 64'd0);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_ir_rel", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("arst_idle%0d_ov", i), 64'(out_valid), 64'd0);
        end

        // Stall counter saturation
        drive(1'b1, 1'b0, 1'b0, 3'b001, 32'hF1);
        tick();
        chk("sat_ov", 64'(out_valid), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        repeat (20) tick();
        chk("sat_stall16", 64'(stall_cnt),  64'd20);
        chk("sat_stall4",  64'(stall_cnt2), 64'd15);
        chk("sat_alu",     64'(o_alu),      64'hF1);

        // Random run against an occupancy/queue model
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        q.delete();
        mcnt = 16'd0;
        for (int n = 0; n < 10000; n++) begin
            chk("rnd_x", 64'($isunknown({in_ready, out_valid, o_ctrl, o_rdata, o_alu, o_dest, stall_cnt})), 64'd0);
            chk("rnd_ov", 64'(out_valid), 64'(q.size() > 0));
            chk("rnd_ir", 64'(in_ready),  64'(q.size() < 2));
            if (q.size() > 0) begin
                chk("rnd_alu",   64'(o_alu),   64'(q[0].alu));
                chk("rnd_rdata", 64'(o_rdata), 64'(q[0].rdata));
                chk("rnd_ctrl",  64'(o_ctrl),  64'(q[0].ctrl));
                chk("rnd_dest",  64'(o_dest),  64'(q[0].dest));
            end else begin
                chk("rnd_bubble_ctrl", 64'(o_ctrl), 64'd0);
            end
            chk("rnd_stall",  64'(stall_cnt),  64'(mcnt));
            chk("rnd_stall4", 64'(stall_cnt2), (mcnt > 16'd15) ? 64'd15 : 64'(mcnt));

            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 63) == 0);
            p.ctrl  = 3'($urandom_range(0, 7));
            p.alu   = $urandom;
            p.rdata = p.alu ^ RD_XOR;
            p.dest  = p.alu[4:0];
            drive(iv, ordy, fl, p.ctrl, p.alu);

            in_x  = iv && (q.size() < 2);
            out_x = (q.size() > 0) && ordy;
            if ((q.size() > 0) && !ordy && (mcnt != 16'hFFFF)) mcnt = mcnt + 16'd1;
            if (fl) begin
                q.delete();
            end else begin
                if (out_x) void'(q.pop_front());
                if (in_x) q.push_back(p);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
